// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - request, timer and status bundle between the pipeline and irq_controller
interface irq_controller_if #(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ID_W      = $clog2(NUM_SRC + 1)
);
  logic [NUM_SRC-1:0]   irq_src;
  logic                 mask_we;
  logic [NUM_SRC:0]     mask_wdata;
  logic                 cnt_int;
  logic                 cnt_int_sel;
  logic                 cnt_int_disable;
  logic [CNT_WIDTH-1:0] cnt_wdata;
  logic                 rti;
  logic                 stallD;
  logic [31:0]          epc_in;
  logic                 int_en1;
  logic [31:0]          int_vector;
  logic [31:0]          epc;
  logic                 in_service;
  logic [ID_W-1:0]      int_id;
  logic [NUM_SRC:0]     pending;

  modport master (
    output irq_src, mask_we, mask_wdata, cnt_int, cnt_int_sel, cnt_int_disable,
           cnt_wdata, rti, stallD, epc_in,
    input  int_en1, int_vector, epc, in_service, int_id, pending
  );

  modport slave (
    input  irq_src, mask_we, mask_wdata, cnt_int, cnt_int_sel, cnt_int_disable,
           cnt_wdata, rti, stallD, epc_in,
    output int_en1, int_vector, epc, in_service, int_id, pending
  );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched external interrupts plus countdown timer, prioritised into one fetch redirect
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0180
) (
  input  logic           clk,
  input  logic           reset,
  irq_controller_if.slave bus
);
  localparam int ID_W = $clog2(NUM_SRC + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   irq_q;
  logic [NUM_SRC:0]     mask_q;
  logic [NUM_SRC:0]     pending_q, pending_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 run_q, run_d;
  logic                 mode_q, mode_d;
  logic                 int_en1_q, int_en1_d;
  logic [31:0]          int_vector_q, int_vector_d;
  logic [31:0]          epc_q, epc_d;
  logic                 in_service_q, in_service_d;
  logic [ID_W-1:0]      int_id_q, int_id_d;

  logic [NUM_SRC:0]     active;
  logic [ID_W-1:0]      winner;
  logic                 tmr_arm, tmr_dis, tmr_fire;

  assign active = pending_q & mask_q;

  // Descending scan so the lowest active index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC; i >= 0; i--) begin
      if (active[i]) winner = ID_W'(i);
    end
  end

  assign tmr_dis  = bus.cnt_int & bus.cnt_int_disable;
  assign tmr_arm  = bus.cnt_int & ~bus.stallD & ~bus.cnt_int_disable;
  // A timer command in the same cycle pre-empts the terminal count.
  assign tmr_fire = run_q & (count_q == CNT_WIDTH'(1)) & ~tmr_arm & ~tmr_dis;

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    run_d    = run_q;
    mode_d   = mode_q;
    if (tmr_dis) begin
      run_d = 1'b0;
    end else if (tmr_arm) begin
      if (bus.cnt_wdata != '0) begin
        count_d  = bus.cnt_wdata;
        period_d = bus.cnt_wdata;
        mode_d   = bus.cnt_int_sel;
        run_d    = 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end else if (run_q) begin
      if (count_q == CNT_WIDTH'(1)) begin
        if (mode_q) run_d = 1'b0;
        else        count_d = period_q;
      end else begin
        count_d = count_q - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    int_en1_d    = int_en1_q;
    int_vector_d = int_vector_q;
    epc_d        = epc_q;
    in_service_d = in_service_q;
    int_id_d     = int_id_q;
    case (state_q)
      S_IDLE: begin
        if (|active) begin
          int_id_d     = winner;
          int_vector_d = VEC_BASE + (32'(winner) << 3);
          int_en1_d    = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (!bus.stallD) begin
          epc_d               = bus.epc_in;
          pending_d[int_id_q] = 1'b0;
          int_en1_d           = 1'b0;
          in_service_d        = 1'b1;
          state_d             = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (bus.rti && !bus.stallD) begin
          in_service_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Sets are applied after the acknowledge clear so a same-cycle event survives.
    pending_d[NUM_SRC-1:0] = pending_d[NUM_SRC-1:0] | (bus.irq_src & ~irq_q);
    if (tmr_fire) pending_d[NUM_SRC] = 1'b1;
    if (tmr_dis)  pending_d[NUM_SRC] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      irq_q        <= '0;
      mask_q       <= '0;
      pending_q    <= '0;
      count_q      <= '0;
      period_q     <= '0;
      run_q        <= 1'b0;
      mode_q       <= 1'b0;
      int_en1_q    <= 1'b0;
      int_vector_q <= VEC_BASE;
      epc_q        <= '0;
      in_service_q <= 1'b0;
      int_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= bus.irq_src;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      pending_q    <= pending_d;
      count_q      <= count_d;
      period_q     <= period_d;
      run_q        <= run_d;
      mode_q       <= mode_d;
      int_en1_q    <= int_en1_d;
      int_vector_q <= int_vector_d;
      epc_q        <= epc_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
    end
  end

  assign bus.int_en1    = int_en1_q;
  assign bus.int_vector = int_vector_q;
  assign bus.epc        = epc_q;
  assign bus.in_service = in_service_q;
  assign bus.int_id     = int_id_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - vector table, corner sequences and randomized run against a reference model
module tb_irq_controller;
  localparam int          NUM_SRC   = 4;
  localparam int          CNT_WIDTH = 16;
  localparam logic [31:0] VEC_BASE  = 32'h0000_0180;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_controller_if #(.NUM_SRC(NUM_SRC), .CNT_WIDTH(CNT_WIDTH)) bus ();

  irq_controller #(.NUM_SRC(NUM_SRC), .CNT_WIDTH(CNT_WIDTH), .VEC_BASE(VEC_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: timer tracked as the absolute cycle of its next fire.
  int          m_t = 0;
  logic [4:0]  m_pend, m_mask;
  logic [3:0]  m_prev;
  bit          m_run, m_oneshot;
  int          m_period, m_next_fire;
  int          m_state;
  bit          m_en, m_svc;
  int          m_id;
  logic [31:0] m_epc;

  typedef struct {
    logic [3:0]  irq;
    logic        mwe;
    logic [4:0]  mw;
    logic        stall;
    logic        rti;
    logic [31:0] epc_in;
    logic        en;
    logic [2:0]  id;
    logic [31:0] vec;
    logic        svc;
    logic [4:0]  pend;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] act, np;
    int win;
    bit arm, dis, fire;
    m_t++;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_run = 0; m_oneshot = 0;
      m_period = 0; m_next_fire = 0; m_state = 0; m_en = 0; m_svc = 0;
      m_id = 0; m_epc = '0;
      return;
    end
    act = m_pend & m_mask;
    win = -1;
    for (int i = 0; i <= NUM_SRC; i++) if (act[i] && win < 0) win = i;
    dis  = bus.cnt_int && bus.cnt_int_disable;
    arm  = bus.cnt_int && !bus.stallD && !bus.cnt_int_disable;
    fire = m_run && (m_t == m_next_fire) && !arm && !dis;
    np = m_pend;
    case (m_state)
      0: if (win >= 0) begin m_id = win; m_en = 1; m_state = 1; end
      1: if (!bus.stallD) begin
           m_epc = bus.epc_in; np[m_id] = 1'b0; m_en = 0; m_svc = 1; m_state = 2;
         end
      default: if (bus.rti && !bus.stallD) begin m_svc = 0; m_state = 0; end
    endcase
    np[3:0] = np[3:0] | (bus.irq_src & ~m_prev);
    if (fire) np[4] = 1'b1;
    if (dis)  np[4] = 1'b0;
    if (dis) m_run = 0;
    else if (arm) begin
      if (bus.cnt_wdata != 0) begin
        m_period = int'(bus.cnt_wdata); m_next_fire = m_t + m_period;
        m_oneshot = bus.cnt_int_sel; m_run = 1;
      end else m_run = 0;
    end else if (fire) begin
      if (m_oneshot) m_run = 0;
      else m_next_fire = m_t + m_period;
    end
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_prev = bus.irq_src;
    m_pend = np;
  endtask

  task automatic check_model();
    logic [31:0] evec;
    evec = VEC_BASE + 32'(m_id * 8);
    n_tests++;
    if (bus.int_en1 !== m_en || bus.int_vector !== evec || bus.epc !== m_epc ||
        bus.in_service !== m_svc || bus.int_id !== 3'(m_id) || bus.pending !== m_pend) begin
      n_fail++;
      $display("FAIL model t=%0d: en %b/%b vec %h/%h epc %h/%h svc %b/%b id %0d/%0d pend %b/%b (got/exp)",
               m_t, bus.int_en1, m_en, bus.int_vector, evec, bus.epc, m_epc,
               bus.in_service, m_svc, bus.int_id, m_id, bus.pending, m_pend);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    bus.irq_src = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.cnt_int = 0;
    bus.cnt_int_sel = 0; bus.cnt_int_disable = 0; bus.cnt_wdata = '0;
    bus.rti = 0; bus.stallD = 0; bus.epc_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic write_mask(input logic [4:0] m);
    bus.mask_we = 1'b1; bus.mask_wdata = m;
    cycle();
    bus.mask_we = 1'b0;
  endtask

  // Caller arms the timer; call 1 is the load cycle.
  task automatic track_timer(input int n, input int gap, output int rises, output int first,
                             output int gaps_bad);
    bit prevp;
    int last;
    prevp = bus.pending[NUM_SRC]; rises = 0; first = -1; gaps_bad = 0; last = -1;
    for (int k = 1; k <= n; k++) begin
      cycle();
      if (k == 1) bus.cnt_int = 1'b0;
      if (bus.pending[NUM_SRC] && !prevp) begin
        rises++;
        if (first < 0) first = k;
        else if (k - last != gap) gaps_bad++;
        last = k;
      end
      prevp = bus.pending[NUM_SRC];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, first, gaps_bad, seen;

    //           irq     mwe  mw        st rti epc_in          en id   vec            svc pend     epc
    tbl[0]  = '{4'b0000, 1, 5'b11111, 0, 0, 32'h0,    0, 3'd0, 32'h180, 0, 5'b00000, 32'h0};
    tbl[1]  = '{4'b0100, 0, 5'b00000, 0, 0, 32'h0,    0, 3'd0, 32'h180, 0, 5'b00100, 32'h0};
    tbl[2]  = '{4'b0100, 0, 5'b00000, 0, 0, 32'h0,    1, 3'd2, 32'h190, 0, 5'b00100, 32'h0};
    tbl[3]  = '{4'b0100, 0, 5'b00000, 0, 0, 32'h1000, 0, 3'd2, 32'h190, 1, 5'b00000, 32'h1000};
    tbl[4]  = '{4'b0000, 0, 5'b00000, 0, 0, 32'h0,    0, 3'd2, 32'h190, 1, 5'b00000, 32'h1000};
    tbl[5]  = '{4'b1010, 0, 5'b00000, 0, 0, 32'h0,    0, 3'd2, 32'h190, 1, 5'b01010, 32'h1000};
    tbl[6]  = '{4'b1010, 0, 5'b00000, 0, 1, 32'h0,    0, 3'd2, 32'h190, 0, 5'b01010, 32'h1000};
    tbl[7]  = '{4'b1010, 0, 5'b00000, 0, 0, 32'h0,    1, 3'd1, 32'h188, 0, 5'b01010, 32'h1000};
    tbl[8]  = '{4'b0000, 0, 5'b00000, 1, 0, 32'h0,    1, 3'd1, 32'h188, 0, 5'b01010, 32'h1000};
    tbl[9]  = '{4'b0000, 0, 5'b00000, 0, 0, 32'h2000, 0, 3'd1, 32'h188, 1, 5'b01000, 32'h2000};
    tbl[10] = '{4'b0000, 0, 5'b00000, 0, 1, 32'h0,    0, 3'd1, 32'h188, 0, 5'b01000, 32'h2000};
    tbl[11] = '{4'b0000, 0, 5'b00000, 0, 0, 32'h0,    1, 3'd3, 32'h198, 0, 5'b01000, 32'h2000};
    tbl[12] = '{4'b0000, 0, 5'b00000, 0, 0, 32'h3000, 0, 3'd3, 32'h198, 1, 5'b00000, 32'h3000};
    tbl[13] = '{4'b0000, 0, 5'b00000, 0, 1, 32'h0,    0, 3'd3, 32'h198, 0, 5'b00000, 32'h3000};
    tbl[14] = '{4'b0000, 0, 5'b00000, 0, 0, 32'h0,    0, 3'd3, 32'h198, 0, 5'b00000, 32'h3000};

    do_reset();
    chk("reset_state", {bus.int_en1, bus.int_vector, bus.epc, bus.in_service, bus.int_id, bus.pending},
        {1'b0, VEC_BASE, 32'h0, 1'b0, 3'd0, 5'b0});

    for (int i = 0; i < 15; i++) begin
      bus.irq_src = tbl[i].irq; bus.mask_we = tbl[i].mwe; bus.mask_wdata = tbl[i].mw;
      bus.stallD = tbl[i].stall; bus.rti = tbl[i].rti; bus.epc_in = tbl[i].epc_in;
      cycle();
      chk($sformatf("table_row_%0d", i),
          {bus.int_en1, bus.int_id, bus.int_vector, bus.in_service, bus.pending, bus.epc},
          {tbl[i].en, tbl[i].id, tbl[i].vec, tbl[i].svc, tbl[i].pend, tbl[i].epc});
    end
    idle_inputs();

    // Stall handshake held in REQ.
    bus.irq_src = 4'b0001;
    cycle();
    cycle();
    chk("stall_req_raised", {79'd0, bus.int_en1}, 80'd1);
    bus.stallD = 1'b1; bus.epc_in = 32'hdead_0000;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("stall_hold_%0d", k), {bus.int_en1, bus.int_vector, bus.epc},
          {1'b1, 32'h180, 32'h3000});
    end
    bus.stallD = 1'b0; bus.epc_in = 32'h4444;
    cycle();
    chk("stall_release", {bus.int_en1, bus.in_service, bus.epc, bus.pending},
        {1'b0, 1'b1, 32'h4444, 5'b0});
    bus.irq_src = '0; bus.rti = 1'b1;
    cycle();
    idle_inputs();

    // Periodic timer, then disable while its pending is set.
    do_reset();
    write_mask(5'b10000);
    bus.rti = 1'b1;
    bus.cnt_int = 1'b1; bus.cnt_int_sel = 1'b0; bus.cnt_wdata = 16'd5;
    track_timer(30, 5, rises, first, gaps_bad);
    chk("periodic_first", 80'(first), 80'd6);
    chk("periodic_rises", 80'(rises), 80'd5);
    chk("periodic_gaps", 80'(gaps_bad), 80'd0);
    write_mask(5'b00000);
    seen = 0;
    for (int k = 0; k < 12 && seen == 0; k++) begin
      cycle();
      if (bus.pending[NUM_SRC]) seen = 1;
    end
    chk("disable_precondition", 80'(seen), 80'd1);
    bus.cnt_int = 1'b1; bus.cnt_int_disable = 1'b1; bus.cnt_int_sel = 1'b1;
    cycle();
    bus.cnt_int = 1'b0; bus.cnt_int_disable = 1'b0;
    chk("disable_clears", {79'd0, bus.pending[NUM_SRC]}, 80'd0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (bus.pending[NUM_SRC]) seen++;
    end
    chk("disable_silent", 80'(seen), 80'd0);

    // One-shot, then a zero write.
    do_reset();
    write_mask(5'b10000);
    bus.rti = 1'b1;
    bus.cnt_int = 1'b1; bus.cnt_int_sel = 1'b1; bus.cnt_wdata = 16'd3;
    track_timer(20, 3, rises, first, gaps_bad);
    chk("oneshot_first", 80'(first), 80'd4);
    chk("oneshot_rises", 80'(rises), 80'd1);
    bus.cnt_int = 1'b1; bus.cnt_int_sel = 1'b0; bus.cnt_wdata = 16'd0;
    track_timer(20, 1, rises, first, gaps_bad);
    chk("zero_never_fires", 80'(rises), 80'd0);
    idle_inputs();

    // Masked pending, unmask latency, reset from SERVICE.
    do_reset();
    bus.irq_src = 4'b0001;
    cycle();
    chk("masked_pending", {bus.int_en1, bus.pending}, {1'b0, 5'b00001});
    for (int k = 0; k < 3; k++) cycle();
    chk("masked_no_req", {79'd0, bus.int_en1}, 80'd0);
    write_mask(5'b00001);
    chk("unmask_plus1", {79'd0, bus.int_en1}, 80'd0);
    cycle();
    chk("unmask_plus2", {bus.int_en1, bus.int_id}, {1'b1, 3'd0});
    bus.epc_in = 32'h5555;
    cycle();
    chk("mask_serviced", {bus.in_service, bus.epc}, {1'b1, 32'h5555});
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_in_service", {bus.int_en1, bus.int_vector, bus.epc, bus.in_service, bus.int_id, bus.pending},
        {1'b0, VEC_BASE, 32'h0, 1'b0, 3'd0, 5'b0});
    idle_inputs();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset               = ($urandom_range(0, 299) == 0);
      bus.irq_src         = bus.irq_src ^ (4'($urandom) & 4'($urandom));
      bus.mask_we         = ($urandom_range(0, 15) == 0);
      bus.mask_wdata      = 5'($urandom);
      bus.cnt_int         = ($urandom_range(0, 19) == 0);
      bus.cnt_int_sel     = 1'($urandom);
      bus.cnt_int_disable = ($urandom_range(0, 3) == 0);
      bus.cnt_wdata       = 16'($urandom_range(0, 9));
      bus.rti             = ($urandom_range(0, 2) == 0);
      bus.stallD          = ($urandom_range(0, 2) == 0);
      bus.epc_in          = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
